// File: rtl/bram_test_pkg.sv
// Shared types and helpers for the BRAM LFSR memory self-test.
// The tester supports optional fault injection under BRAM_TEST_FAULT_INJECT_EN.
package bram_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_VERIFY,
    ST_DRAIN,
    ST_DONE
  } bram_test_state_t;

  // x^32 + x^22 + x^2 + x + 1, Galois form
  localparam logic [31:0] LFSR_POLY_DEFAULT = 32'h80200003;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s,
                                            input logic [31:0] poly = LFSR_POLY_DEFAULT);
    return (s >> 1) ^ (s[0] ? poly : 32'h0);
  endfunction

endpackage

// File: rtl/bram_lfsr_tester_lfsr32_gen.sv
// 32-bit Galois LFSR with synchronous load/step; a zero seed loads 32'h1
// because the all-zero state would never leave itself.
module lfsr32_gen
  import bram_test_pkg::*;
#(
  parameter logic [31:0] POLY = LFSR_POLY_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] seed,
  output logic [31:0] value
);

  logic [31:0] value_d;
  logic [31:0] value_q;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = (seed == 32'h0) ? 32'h1 : seed;
    end else if (step) begin
      value_d = lfsr_step(value_q, POLY);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= 32'h1;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/bram_lfsr_tester.sv
// BRAM self-test: fills the BRAM with an LFSR sequence, reads it back and
// reports pass/fail status. Optional BRAM_TEST_FAULT_INJECT_EN adds fault_inject.
module bram_lfsr_tester
  import bram_test_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter int          DATA_W    = 32,
  parameter logic [31:0] LFSR_POLY = LFSR_POLY_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       seed_data,
  input  logic              seed_valid,
`ifdef BRAM_TEST_FAULT_INJECT_EN
  input  logic              fault_inject,
`endif
  output logic              busy,
  output logic              status_done,
  output logic              status_pass,
  output logic [ADDR_W:0]   error_count,
  output logic [ADDR_W-1:0] first_error_addr,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  input  logic [DATA_W-1:0] bram_rdata
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [ADDR_W:0]   ERR_MAX   = {1'b1, {ADDR_W{1'b0}}};

  bram_test_state_t  state_d, state_q;
  logic [31:0]       seed_d, seed_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic              en_d, en_q;
  logic              we_d, we_q;
  logic              busy_d, busy_q;
  logic              done_d, done_q;
  logic              pass_d, pass_q;
  logic [ADDR_W:0]   err_d, err_q;
  logic [ADDR_W-1:0] first_d, first_q;
  logic [31:0]       exp_d, exp_q;
  logic              cmp_valid_d, cmp_valid_q;
  logic [ADDR_W-1:0] cmp_addr_d, cmp_addr_q;
  logic              fault_d, fault_q;

  logic              lfsr_load;
  logic              lfsr_step_en;
  logic [31:0]       lfsr_seed;
  logic [31:0]       lfsr_value;
  logic              mismatch;

  lfsr32_gen #(
    .POLY (LFSR_POLY)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (lfsr_load),
    .step  (lfsr_step_en),
    .seed  (lfsr_seed),
    .value (lfsr_value)
  );

  // bram_rdata arrives one cycle after the read, so it meets the delayed expected word
  assign mismatch = cmp_valid_q && (bram_rdata != exp_q);

  always_comb begin
    state_d      = state_q;
    seed_d       = seed_q;
    addr_d       = addr_q;
    en_d         = en_q;
    we_d         = we_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    err_d        = err_q;
    first_d      = first_q;
    exp_d        = exp_q;
    cmp_valid_d  = 1'b0;
    cmp_addr_d   = cmp_addr_q;
    fault_d      = fault_q;
    lfsr_load    = 1'b0;
    lfsr_step_en = 1'b0;
    lfsr_seed    = seed_q;

    if (mismatch) begin
      if (err_q != ERR_MAX) begin
        err_d = err_q + 1'b1;
      end
      if (err_q == '0) begin
        first_d = cmp_addr_q;
      end
    end

    case (state_q)
      ST_FILL: begin
        if (addr_q == ADDR_LAST) begin
          state_d   = ST_VERIFY;
          addr_d    = '0;
          we_d      = 1'b0;
          lfsr_load = 1'b1;
        end else begin
          addr_d       = addr_q + 1'b1;
          lfsr_step_en = 1'b1;
        end
      end
      ST_VERIFY: begin
        exp_d       = lfsr_value;
        cmp_valid_d = 1'b1;
        cmp_addr_d  = addr_q;
        if (addr_q == ADDR_LAST) begin
          state_d = ST_DRAIN;
          addr_d  = '0;
          en_d    = 1'b0;
        end else begin
          addr_d       = addr_q + 1'b1;
          lfsr_step_en = 1'b1;
        end
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!done_q) begin
          done_d = 1'b1;
          pass_d = (err_q == '0);
          busy_d = 1'b0;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase

    // A new seed always wins, aborting any run in flight without a done pulse
    if (seed_valid) begin
      state_d      = ST_FILL;
      seed_d       = seed_data;
      lfsr_seed    = seed_data;
      lfsr_load    = 1'b1;
      lfsr_step_en = 1'b0;
      addr_d       = '0;
      en_d         = 1'b1;
      we_d         = 1'b1;
      busy_d       = 1'b1;
      done_d       = 1'b0;
      pass_d       = 1'b0;
      err_d        = '0;
      first_d      = '0;
      cmp_valid_d  = 1'b0;
`ifdef BRAM_TEST_FAULT_INJECT_EN
      fault_d      = fault_inject;
`else
      fault_d      = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      seed_q      <= '0;
      addr_q      <= '0;
      en_q        <= 1'b0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      first_q     <= '0;
      exp_q       <= '0;
      cmp_valid_q <= 1'b0;
      cmp_addr_q  <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      seed_q      <= seed_d;
      addr_q      <= addr_d;
      en_q        <= en_d;
      we_q        <= we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      first_q     <= first_d;
      exp_q       <= exp_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_addr_q  <= cmp_addr_d;
      fault_q     <= fault_d;
    end
  end

  assign busy             = busy_q;
  assign status_done      = done_q;
  assign status_pass      = pass_q;
  assign error_count      = err_q;
  assign first_error_addr = first_q;
  assign bram_en          = en_q;
  assign bram_we          = we_q;
  assign bram_addr        = addr_q;

  // Write data is gated so the bus reads zero whenever no write is in progress
`ifdef BRAM_TEST_FAULT_INJECT_EN
  logic [31:0] fault_mask;
  assign fault_mask = {31'b0, fault_q && (addr_q == ADDR_W'(3))};
  assign bram_wdata = we_q ? DATA_W'(lfsr_value ^ fault_mask) : '0;
`else
  assign bram_wdata = we_q ? DATA_W'(lfsr_value) : '0;
`endif

endmodule

// File: tb/tb_bram_lfsr_tester.sv
// Directed bench for bram_lfsr_tester with a 1-cycle BRAM model whose read
// path can be corrupted at chosen addresses.
module tb_bram_lfsr_tester;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       seed_data;
  logic              seed_valid;
`ifdef BRAM_TEST_FAULT_INJECT_EN
  logic              fault_inject;
`endif
  logic              busy;
  logic              status_done;
  logic              status_pass;
  logic [ADDR_W:0]   error_count;
  logic [ADDR_W-1:0] first_error_addr;
  logic              bram_en;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [31:0]       bram_wdata;
  logic [31:0]       bram_rdata;

  logic [31:0] mem [DEPTH];
  int          corrupt_a = -1;
  int          corrupt_b = -1;
  bit          corrupt_all = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] seed;
    int          corrupt_a;
    int          corrupt_b;
    bit          corrupt_all;
    bit          exp_pass;
    logic [10:0] exp_err;
    logic [9:0]  exp_first;
    logic [31:0] exp_word0;
    logic [31:0] exp_word1;
    bit          chk_word1;
  } vec_t;

  vec_t vecs [7];

  bram_lfsr_tester dut (
    .clk              (clk),
    .reset            (reset),
    .seed_data        (seed_data),
    .seed_valid       (seed_valid),
`ifdef BRAM_TEST_FAULT_INJECT_EN
    .fault_inject     (fault_inject),
`endif
    .busy             (busy),
    .status_done      (status_done),
    .status_pass      (status_pass),
    .error_count      (error_count),
    .first_error_addr (first_error_addr),
    .bram_en          (bram_en),
    .bram_we          (bram_we),
    .bram_addr        (bram_addr),
    .bram_wdata       (bram_wdata),
    .bram_rdata       (bram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] corrupt_mask(input int a);
    return (corrupt_all || a == corrupt_a || a == corrupt_b) ? 32'h1 : 32'h0;
  endfunction

  // Behavioural single-port BRAM; corruption stands in for a flipped stored word
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) mem[bram_addr] <= bram_wdata;
      else         bram_rdata <= mem[bram_addr] ^ corrupt_mask(int'(bram_addr));
    end
  end

  function automatic logic [31:0] model_next(input logic [31:0] s);
    logic [31:0] n;
    n = {1'b0, s[31:1]};
    if (s[0]) n = n ^ 32'h80200003;
    return n;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkModel(input logic [31:0] seed);
    logic [31:0] s;
    int bad;
    s   = (seed == 32'h0) ? 32'h1 : seed;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem[i] !== s) bad++;
      s = model_next(s);
    end
    checkOutput("model_contents", bad, 0);
  endtask

  task automatic pulseSeed(input logic [31:0] seed);
    @(negedge clk);
    seed_data  = seed;
    seed_valid = 1'b1;
    @(posedge clk);
    #1;
    seed_valid = 1'b0;
    checkOutput("busy_start", busy, 1);
  endtask

  // Counts edges from the accepted seed until status_done, bounded
  task automatic waitDone(output int latency);
    int busy_gap;
    busy_gap = 0;
    latency  = 9999;
    for (int k = 1; k <= 3000; k++) begin
      @(posedge clk);
      #1;
      if (status_done) begin
        latency = k;
        break;
      end
      if (!busy) busy_gap++;
    end
    checkOutput("busy_hold", busy_gap, 0);
    checkOutput("busy_end", busy, 0);
  endtask

  task automatic applyStimulus(input vec_t v, output int latency);
    corrupt_a   = v.corrupt_a;
    corrupt_b   = v.corrupt_b;
    corrupt_all = v.corrupt_all;
    pulseSeed(v.seed);
    waitDone(latency);
  endtask

  initial begin
    int lat;

    vecs[0] = '{32'hdeadbeef, -1, -1, 1'b0, 1'b1, 11'd0, 10'd0, 32'hdeadbeef, 32'hef76df74, 1'b1};
    vecs[1] = '{32'h00000000, -1, -1, 1'b0, 1'b1, 11'd0, 10'd0, 32'h00000001, 32'h80200003, 1'b1};
    vecs[2] = '{32'h12345678, 17, -1, 1'b0, 1'b0, 11'd1, 10'd17, 32'h12345678, 32'h0, 1'b0};
    vecs[3] = '{32'hcafef00d, 900, 5, 1'b0, 1'b0, 11'd2, 10'd5, 32'hcafef00d, 32'h0, 1'b0};
    vecs[4] = '{32'h80000000, 1023, -1, 1'b0, 1'b0, 11'd1, 10'd1023, 32'h80000000, 32'h40000000, 1'b1};
    vecs[5] = '{32'h13579bdf, 0, 1023, 1'b0, 1'b0, 11'd2, 10'd0, 32'h13579bdf, 32'h0, 1'b0};
    vecs[6] = '{32'ha5a5a5a5, -1, -1, 1'b1, 1'b0, 11'd1024, 10'd0, 32'ha5a5a5a5, 32'h0, 1'b0};

    reset      = 1'b1;
    seed_data  = 32'h0;
    seed_valid = 1'b0;
`ifdef BRAM_TEST_FAULT_INJECT_EN
    fault_inject = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outputs",
                {busy, status_done, status_pass, error_count, first_error_addr,
                 bram_en, bram_we, bram_addr}, 32'h0);
    checkOutput("reset_wdata", bram_wdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      $display("[TB] vector %0d seed %h", i, vecs[i].seed);
      applyStimulus(vecs[i], lat);
      checkOutput("done_latency", lat, 2050);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("done_sticky", status_done, 1);
      checkOutput("pass", status_pass, vecs[i].exp_pass);
      checkOutput("error_count", error_count, vecs[i].exp_err);
      checkOutput("first_error_addr", first_error_addr, vecs[i].exp_first);
      checkOutput("word0", mem[0], vecs[i].exp_word0);
      if (vecs[i].chk_word1) checkOutput("word1", mem[1], vecs[i].exp_word1);
      checkModel(vecs[i].seed);
    end
    corrupt_a   = -1;
    corrupt_b   = -1;
    corrupt_all = 1'b0;

    $display("[TB] restart during FILL");
    pulseSeed(32'h11112222);
    repeat (500) @(posedge clk);
    #1;
    checkOutput("fill_in_progress", {busy, bram_we, status_done}, 3'b110);
    pulseSeed(32'h33334444);
    checkOutput("restart_addr", bram_addr, 0);
    waitDone(lat);
    checkOutput("restart_latency", lat, 2050);
    checkOutput("restart_pass", {status_pass, error_count}, {1'b1, 11'd0});
    checkModel(32'h33334444);

    $display("[TB] seed held for three cycles");
    @(negedge clk);
    seed_data  = 32'h55556666;
    seed_valid = 1'b1;
    @(negedge clk);
    seed_data  = 32'h77778888;
    pulseSeed(32'h9999aaaa);
    waitDone(lat);
    checkOutput("held_latency", lat, 2050);
    checkOutput("held_pass", status_pass, 1);
    checkModel(32'h9999aaaa);

    $display("[TB] reset during VERIFY");
    corrupt_a = 40;
    pulseSeed(32'h0badf00d);
    repeat (1024 + 200) @(posedge clk);
    #1;
    checkOutput("in_verify", {busy, bram_en, bram_we}, 3'b110);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrun_reset_outputs",
                {busy, status_done, status_pass, error_count, first_error_addr,
                 bram_en, bram_we, bram_addr}, 32'h0);
    checkOutput("midrun_reset_wdata", bram_wdata, 32'h0);
    @(negedge clk);
    reset     = 1'b0;
    corrupt_a = -1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("idle_after_reset", {busy, bram_en, status_done}, 3'b000);
    pulseSeed(32'hfeedface);
    waitDone(lat);
    checkOutput("post_reset_latency", lat, 2050);
    checkOutput("post_reset_pass", {status_pass, error_count, first_error_addr},
                {1'b1, 11'd0, 10'd0});
    checkModel(32'hfeedface);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
